// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with byte enables, selectable read-during-write,
// optional output register, same-address collision flag and post-reset memory clear.
module dual_port_ram_param #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             busy,
  input  logic                             a_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_din,
  output logic [DATA_WIDTH-1:0]            a_dout,
  output logic                             a_valid,
  input  logic                             b_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]            b_din,
  output logic [DATA_WIDTH-1:0]            b_dout,
  output logic                             b_valid,
  output logic                             collision
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    a_acc, b_acc, same_addr, col_hit;
  logic [DATA_WIDTH-1:0]   a_old, b_old, a_rd, b_rd;
  logic                    a_vld_p1, b_vld_p1, col_p1;
  logic [DATA_WIDTH-1:0]   a_data_p1, b_data_p1;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         lane_we
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (&cnt) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy      = (state == CLEAR);
  assign a_acc     = a_en && (state == READY);
  assign b_acc     = b_en && (state == READY);
  assign same_addr = (a_addr == b_addr);
  assign col_hit   = a_acc && b_acc && same_addr && ((|a_we) || (|b_we));
  assign a_old     = mem[a_addr];
  assign b_old     = mem[b_addr];

  // Write-first only merges a port's own lanes; the other port's write is never forwarded.
  always_comb begin
    a_rd = a_old;
    b_rd = b_old;
    if (WRITE_MODE == 1) begin
      a_rd = merge_lanes(a_old, a_din, a_we);
      b_rd = merge_lanes(b_old, b_din, b_we);
    end
  end

  // Same-address double write: B lanes first, then A lanes on top so A wins overlaps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (a_acc && b_acc && same_addr) begin
        mem[a_addr] <= merge_lanes(merge_lanes(a_old, b_din, b_we), a_din, a_we);
      end else begin
        if (a_acc && (|a_we)) mem[a_addr] <= merge_lanes(a_old, a_din, a_we);
        if (b_acc && (|b_we)) mem[b_addr] <= merge_lanes(b_old, b_din, b_we);
      end
    end
  end

  // ---- stage p1: array read register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld_p1  <= 1'b0;
      b_vld_p1  <= 1'b0;
      col_p1    <= 1'b0;
      a_data_p1 <= '0;
      b_data_p1 <= '0;
    end else begin
      a_vld_p1 <= a_acc;
      b_vld_p1 <= b_acc;
      col_p1   <= col_hit;
      if (a_acc) a_data_p1 <= a_rd;
      if (b_acc) b_data_p1 <= b_rd;
    end
  end

  assign collision = col_p1;

  // ---- stage p2: optional output register ----
  if (OUT_REG != 0) begin : g_out_reg
    logic                  a_vld_p2, b_vld_p2;
    logic [DATA_WIDTH-1:0] a_data_p2, b_data_p2;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_vld_p2  <= 1'b0;
        b_vld_p2  <= 1'b0;
        a_data_p2 <= '0;
        b_data_p2 <= '0;
      end else begin
        a_vld_p2 <= a_vld_p1;
        b_vld_p2 <= b_vld_p1;
        if (a_vld_p1) a_data_p2 <= a_data_p1;
        if (b_vld_p1) b_data_p2 <= b_data_p1;
      end
    end

    assign a_valid = a_vld_p2;
    assign b_valid = b_vld_p2;
    assign a_dout  = a_data_p2;
    assign b_dout  = b_data_p2;
  end else begin : g_no_out_reg
    assign a_valid = a_vld_p1;
    assign b_valid = b_vld_p1;
    assign a_dout  = a_data_p1;
    assign b_dout  = b_data_p1;
  end
endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param: read-first, write-first and output-registered
// instances share one stimulus stream; expectations are queued per output stream.
module tb_dual_port_ram_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_en, b_en;
  logic [1:0]  a_we, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_din, b_din;

  logic        busy0, busy1, busy2, col0, col1, col2;
  logic        a_valid0, a_valid1, a_valid2, b_valid0, b_valid1, b_valid2;
  logic [15:0] a_dout0, a_dout1, a_dout2, b_dout0, b_dout1, b_dout2;

  always #5 clk = ~clk;

  dual_port_ram_param #(.WRITE_MODE(0), .OUT_REG(0)) u_rf (
    .clk(clk), .rst(rst), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0), .a_valid(a_valid0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0), .b_valid(b_valid0),
    .collision(col0));

  dual_port_ram_param #(.WRITE_MODE(1), .OUT_REG(0)) u_wf (
    .clk(clk), .rst(rst), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1), .a_valid(a_valid1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1), .b_valid(b_valid1),
    .collision(col1));

  dual_port_ram_param #(.WRITE_MODE(0), .OUT_REG(1)) u_oreg (
    .clk(clk), .rst(rst), .busy(busy2),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout2), .a_valid(a_valid2),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout2), .b_valid(b_valid2),
    .collision(col2));

  typedef struct {
    logic        ae;
    logic [1:0]  awe;
    logic [3:0]  aaddr;
    logic [15:0] adin;
    logic        be;
    logic [1:0]  bwe;
    logic [3:0]  baddr;
    logic [15:0] bdin;
    logic [15:0] ea;   // port A result, read-first
    logic [15:0] eaw;  // port A result, write-first
    logic [15:0] eb;
    logic [15:0] ebw;
    logic        col;
  } vec_t;

  typedef struct {
    int          id;
    int          due;
    logic [15:0] data;
  } sb_t;

  sb_t  q[$];
  vec_t tbl[18];
  vec_t idle, busyv;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  function automatic vec_t mk(input logic ae, input logic [1:0] awe, input logic [3:0] aaddr,
                              input logic [15:0] adin, input logic be, input logic [1:0] bwe,
                              input logic [3:0] baddr, input logic [15:0] bdin,
                              input logic [15:0] ea, input logic [15:0] eaw,
                              input logic [15:0] eb, input logic [15:0] ebw, input logic col);
    vec_t v;
    v.ae = ae; v.awe = awe; v.aaddr = aaddr; v.adin = adin;
    v.be = be; v.bwe = bwe; v.baddr = baddr; v.bdin = bdin;
    v.ea = ea; v.eaw = eaw; v.eb = eb; v.ebw = ebw; v.col = col;
    return v;
  endfunction

  task automatic push(input int id, input int due, input logic [15:0] data);
    sb_t e;
    e.id = id; e.due = due; e.data = data;
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %h want %h", nm, cyc, got, want);
    end
  endtask

  task automatic check_stream(input int id, input string nm, input logic vld, input logic [15:0] dout);
    int   idx;
    logic exp_v;
    idx = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].id == id) begin
        idx = i;
        break;
      end
    end
    exp_v = (idx >= 0) && (q[idx].due == cyc);
    cmp({nm, "_valid"}, {15'd0, vld}, {15'd0, exp_v});
    if (exp_v) begin
      cmp({nm, "_dout"}, dout, q[idx].data);
      q.delete(idx);
    end
  endtask

  task automatic step(input vec_t v, input logic r);
    logic gate, exp_col;
    gate = r || (busy0 !== 1'b0);
    rst = r;
    a_en = v.ae; a_we = v.awe; a_addr = v.aaddr; a_din = v.adin;
    b_en = v.be; b_we = v.bwe; b_addr = v.baddr; b_din = v.bdin;
    if (r) q.delete();
    if (!gate) begin
      if (v.ae) begin
        push(0, cyc + 1, v.ea); push(2, cyc + 1, v.eaw); push(4, cyc + 2, v.ea);
      end
      if (v.be) begin
        push(1, cyc + 1, v.eb); push(3, cyc + 1, v.ebw); push(5, cyc + 2, v.eb);
      end
    end
    exp_col = gate ? 1'b0 : (v.ae && v.be && v.col);
    @(posedge clk);
    cyc++;
    #1;
    check_stream(0, "a_rf", a_valid0, a_dout0);
    check_stream(1, "b_rf", b_valid0, b_dout0);
    check_stream(2, "a_wf", a_valid1, a_dout1);
    check_stream(3, "b_wf", b_valid1, b_dout1);
    check_stream(4, "a_oreg", a_valid2, a_dout2);
    check_stream(5, "b_oreg", b_valid2, b_dout2);
    cmp("col_rf", {15'd0, col0}, {15'd0, exp_col});
    cmp("col_wf", {15'd0, col1}, {15'd0, exp_col});
    cmp("col_oreg", {15'd0, col2}, {15'd0, exp_col});
  endtask

  // Counts samples with busy high, starting from the sample after the last rst edge.
  task automatic wait_ready(input vec_t v);
    int n;
    n = 0;
    while (busy0 !== 1'b0 && n < 40) begin
      n++;
      step(v, 1'b0);
    end
    cmp("busy_cycles", 16'(n), 16'd16);
    cmp("busy_wf_low", {15'd0, busy1}, 16'd0);
    cmp("busy_oreg_low", {15'd0, busy2}, 16'd0);
  endtask

  task automatic check_reset_state();
    cmp("rst_busy_rf", {15'd0, busy0}, 16'd1);
    cmp("rst_busy_wf", {15'd0, busy1}, 16'd1);
    cmp("rst_busy_oreg", {15'd0, busy2}, 16'd1);
    cmp("rst_a_dout_rf", a_dout0, 16'h0000);
    cmp("rst_b_dout_wf", b_dout1, 16'h0000);
    cmp("rst_a_dout_oreg", a_dout2, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle  = mk(0, 2'b00, 4'd0, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    busyv = mk(1, 2'b11, 4'd5, 16'hFFFF, 1, 2'b00, 4'd5, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
    //              ae awe   aaddr adin      be bwe   baddr bdin       ea        eaw       eb        ebw       col
    tbl[0]  = mk(1, 2'b11, 4'd5, 16'hBEEF, 0, 2'b00, 4'd0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 0);
    tbl[1]  = mk(1, 2'b11, 4'd3, 16'h1234, 1, 2'b11, 4'd7, 16'h1111, 16'h0000, 16'h1234, 16'h0000, 16'h1111, 0);
    tbl[2]  = mk(1, 2'b10, 4'd3, 16'hAB56, 1, 2'b11, 4'd2, 16'h0F0F, 16'h1234, 16'hAB34, 16'h0000, 16'h0F0F, 0);
    tbl[3]  = mk(1, 2'b00, 4'd5, 16'h0000, 1, 2'b00, 4'd3, 16'h0000, 16'hBEEF, 16'hBEEF, 16'hAB34, 16'hAB34, 0);
    tbl[4]  = mk(1, 2'b11, 4'd7, 16'h2222, 0, 2'b00, 4'd0, 16'h0000, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 0);
    tbl[5]  = mk(1, 2'b00, 4'd7, 16'h0000, 1, 2'b11, 4'd9, 16'h0000, 16'h2222, 16'h2222, 16'h0000, 16'h0000, 0);
    tbl[6]  = mk(1, 2'b01, 4'd9, 16'hAAAA, 1, 2'b11, 4'd9, 16'hBBBB, 16'h0000, 16'h00AA, 16'h0000, 16'hBBBB, 1);
    tbl[7]  = mk(1, 2'b00, 4'd9, 16'h0000, 1, 2'b00, 4'd9, 16'h0000, 16'hBBAA, 16'hBBAA, 16'hBBAA, 16'hBBAA, 0);
    tbl[8]  = mk(1, 2'b00, 4'd2, 16'h0000, 1, 2'b11, 4'd2, 16'hF0F0, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'hF0F0, 1);
    tbl[9]  = mk(1, 2'b00, 4'd2, 16'h0000, 0, 2'b00, 4'd0, 16'h0000, 16'hF0F0, 16'hF0F0, 16'h0000, 16'h0000, 0);
    tbl[10] = mk(1, 2'b11, 4'd0, 16'h0100, 1, 2'b11, 4'd1, 16'h0101, 16'h0000, 16'h0100, 16'h0000, 16'h0101, 0);
    tbl[11] = mk(1, 2'b11, 4'd2, 16'h0102, 0, 2'b00, 4'd0, 16'h0000, 16'hF0F0, 16'h0102, 16'h0000, 16'h0000, 0);
    tbl[12] = mk(1, 2'b00, 4'd0, 16'h0000, 1, 2'b00, 4'd1, 16'h0000, 16'h0100, 16'h0100, 16'h0101, 16'h0101, 0);
    tbl[13] = mk(1, 2'b00, 4'd1, 16'h0000, 1, 2'b01, 4'd1, 16'h00FF, 16'h0101, 16'h0101, 16'h0101, 16'h01FF, 1);
    tbl[14] = mk(1, 2'b00, 4'd2, 16'h0000, 1, 2'b00, 4'd1, 16'h0000, 16'h0102, 16'h0102, 16'h01FF, 16'h01FF, 0);
    tbl[15] = idle;
    tbl[16] = mk(0, 2'b11, 4'd0, 16'hFFFF, 1, 2'b00, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 0);
    tbl[17] = mk(1, 2'b00, 4'd9, 16'h0000, 1, 2'b00, 4'd0, 16'h0000, 16'hBBAA, 16'hBBAA, 16'h0100, 16'h0100, 0);

    rst = 1'b1;
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;

    step(idle, 1'b1);
    step(idle, 1'b1);
    check_reset_state();
    wait_ready(idle);

    for (int i = 0; i < 18; i++) step(tbl[i], 1'b0);

    step(idle, 1'b0);
    step(idle, 1'b0);
    cmp("hold_a_rf", a_dout0, 16'hBBAA);
    cmp("hold_a_wf", a_dout1, 16'hBBAA);
    cmp("hold_a_oreg", a_dout2, 16'hBBAA);
    cmp("hold_b_oreg", b_dout2, 16'h0100);

    // Reset lands while a read is still in flight in the output-registered copy.
    step(mk(1, 2'b00, 4'd0, 16'h0, 0, 2'b00, 4'd0, 16'h0, 16'h0100, 16'h0100, 16'h0, 16'h0, 0), 1'b0);
    step(mk(1, 2'b00, 4'd1, 16'h0, 0, 2'b00, 4'd0, 16'h0, 16'h0101, 16'h0101, 16'h0, 16'h0, 0), 1'b1);
    check_reset_state();
    wait_ready(busyv);

    step(mk(1, 2'b00, 4'd5, 16'h0, 1, 2'b00, 4'd0, 16'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0), 1'b0);
    step(idle, 1'b0);
    step(idle, 1'b0);
    cmp("sb_drained", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
